// File: rtl/rom_port_arbiter.sv
// Purpose : shares the SDRAM ROM read port between CPU program fetch and sprite/tile DMA, with a one-word CPU cache.
// Latency : cache hit acks 1 cycle after req is sampled; a miss acks 1 cycle after sdr_ack is sampled.
// Backpress: requesters hold a level req until their one-cycle ack; the SDRAM side holds sdr_req until sdr_ack.
//
// Ports:
//   clk, reset_n              single clock, async active-low reset
//   cpu_req/cpu_addr          CPU read request, 20-bit ROM byte address (bit 0 ignored)
//   cpu_data/cpu_ack          CPU read data, valid with the one-cycle ack
//   dma_req/dma_addr          DMA read request, absolute SDRAM byte address (bit 0 ignored)
//   dma_data/dma_ack          DMA read data, valid with the one-cycle ack
//   cache_flush               one-cycle pulse invalidating the cached word
//   sdr_req/sdr_addr          SDRAM read request and word-aligned byte address
//   sdr_q/sdr_ack             SDRAM read data and its one-cycle valid pulse
module rom_port_arbiter #(
    parameter int              SDR_AW       = 25,
    parameter logic [SDR_AW-1:0] CPU_ROM_BASE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic [19:0]       cpu_addr,
    output logic [15:0]       cpu_data,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic [SDR_AW-1:0] dma_addr,
    output logic [15:0]       dma_data,
    output logic              dma_ack,
    input  logic              cache_flush,
    output logic              sdr_req,
    output logic [SDR_AW-1:0] sdr_addr,
    input  logic [15:0]       sdr_q,
    input  logic              sdr_ack
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_WAIT = 2'd1,
        DMA_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t state;

    // One-entry last-word cache, tagged by the CPU word address.
    logic        cache_vld;
    logic [18:0] cache_tag;
    logic [15:0] cache_dat;

    // Round-robin memory: 1 = DMA was granted last. Hits never touch it.
    logic        last_grant_dma;

    logic              cache_hit;
    logic              grant_cpu;
    logic              grant_dma;
    logic [SDR_AW-1:0] cpu_sum;
    logic [SDR_AW-1:0] cpu_sdr_addr;
    logic [SDR_AW-1:0] dma_sdr_addr;

    assign cache_hit = cpu_req && cache_vld && (cache_tag == cpu_addr[19:1]);

    // Grant decision for an IDLE cycle without a hit. Under contention the
    // requester that was not served last wins, so grants strictly alternate.
    always_comb begin
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        if (!cache_hit) begin
            if (cpu_req && dma_req) begin
                grant_dma = !last_grant_dma;
                grant_cpu = last_grant_dma;
            end else begin
                grant_cpu = cpu_req;
                grant_dma = dma_req;
            end
        end
    end

    // CPU addresses are relative to the ROM region; wrap modulo 2^SDR_AW.
    assign cpu_sum      = CPU_ROM_BASE + SDR_AW'({cpu_addr[19:1], 1'b0});
    assign cpu_sdr_addr = {cpu_sum[SDR_AW-1:1], 1'b0};
    assign dma_sdr_addr = {dma_addr[SDR_AW-1:1], 1'b0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            sdr_req        <= 1'b0;
            sdr_addr       <= '0;
            cpu_ack        <= 1'b0;
            dma_ack        <= 1'b0;
            cpu_data       <= '0;
            dma_data       <= '0;
            cache_vld      <= 1'b0;
            cache_tag      <= '0;
            cache_dat      <= '0;
            last_grant_dma <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cache_hit) begin
                        cpu_data <= cache_dat;
                        cpu_ack  <= 1'b1;
                        state    <= RESP;
                    end else if (grant_cpu) begin
                        sdr_addr       <= cpu_sdr_addr;
                        sdr_req        <= 1'b1;
                        last_grant_dma <= 1'b0;
                        state          <= CPU_WAIT;
                    end else if (grant_dma) begin
                        sdr_addr       <= dma_sdr_addr;
                        sdr_req        <= 1'b1;
                        last_grant_dma <= 1'b1;
                        state          <= DMA_WAIT;
                    end
                end
                CPU_WAIT: begin
                    if (sdr_ack) begin
                        sdr_req   <= 1'b0;
                        cpu_data  <= sdr_q;
                        cpu_ack   <= 1'b1;
                        cache_vld <= 1'b1;
                        cache_tag <= cpu_addr[19:1];
                        cache_dat <= sdr_q;
                        state     <= RESP;
                    end
                end
                DMA_WAIT: begin
                    if (sdr_ack) begin
                        sdr_req  <= 1'b0;
                        dma_data <= sdr_q;
                        dma_ack  <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    // Acks are one-cycle pulses; the requester drops req now.
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Placed last so a flush overrides a fill in the same cycle.
            if (cache_flush) begin
                cache_vld <= 1'b0;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{cpu_addr[0], dma_addr[0], cpu_sum[0]};

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;

    localparam logic [24:0] BASE = 25'h100000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [19:0] cpu_addr = '0;
    logic [15:0] cpu_data;
    logic        cpu_ack;
    logic        dma_req = 1'b0;
    logic [24:0] dma_addr = '0;
    logic [15:0] dma_data;
    logic        dma_ack;
    logic        sdr_req;
    logic [24:0] sdr_addr;
    logic [15:0] sdr_q = '0;
    logic        sdr_ack = 1'b0;
    logic        flush_pulse = 1'b0;
    logic        flush_on_ack = 1'b0;
    wire         cache_flush = flush_pulse | (flush_on_ack & sdr_ack);

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rom_port_arbiter #(.SDR_AW(25), .CPU_ROM_BASE(BASE)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_ack     (cpu_ack),
        .dma_req     (dma_req),
        .dma_addr    (dma_addr),
        .dma_data    (dma_data),
        .dma_ack     (dma_ack),
        .cache_flush (cache_flush),
        .sdr_req     (sdr_req),
        .sdr_addr    (sdr_addr),
        .sdr_q       (sdr_q),
        .sdr_ack     (sdr_ack)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // ---------------- SDRAM responder ----------------
    bit          use_fixed = 1'b1;
    int          fixed_lat = 5;
    logic [15:0] fixed_data = '0;
    bit          rand_spur = 1'b0;
    int          spur_req_cnt = 0;
    int          spur_done = 0;
    bit          rsp_busy = 1'b0;
    int          rsp_cnt = 0;

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sdr_ack  = 1'b0;
            sdr_q    = '0;
            rsp_busy = 1'b0;
            rsp_cnt  = 0;
        end else if (sdr_ack) begin
            sdr_ack = 1'b0;
        end else if (rsp_busy) begin
            if (rsp_cnt <= 1) begin
                sdr_ack  = 1'b1;
                sdr_q    = use_fixed ? fixed_data : 16'($urandom);
                rsp_busy = 1'b0;
            end else begin
                rsp_cnt--;
            end
        end else if (sdr_req) begin
            rsp_busy = 1'b1;
            rsp_cnt  = use_fixed ? fixed_lat : int'($urandom_range(1, 5));
        end else if (spur_done != spur_req_cnt) begin
            sdr_ack = 1'b1;
            sdr_q   = 16'hDEAD;
            spur_done++;
        end else if (rand_spur && $urandom_range(0, 9) == 0) begin
            sdr_ack = 1'b1;
            sdr_q   = 16'($urandom);
        end
    end

    // ---------------- Behavioural reference model ----------------
    // Transaction view: a word is either being fetched from SDRAM for one
    // owner, or is being handed back (the ack cycle), or the port is free.
    bit          m_fetching = 1'b0;
    bit          m_owner_dma = 1'b0;
    bit          m_handing_back = 1'b0;
    bit          m_cvld = 1'b0;
    logic [18:0] m_ctag = '0;
    logic [15:0] m_cdat = '0;
    bit          m_last_dma = 1'b1;
    bit          m_hit = 1'b0;
    int          m_hits = 0;
    logic        exp_sdr_req = 1'b0;
    logic [24:0] exp_sdr_addr = '0;
    logic        exp_cpu_ack = 1'b0;
    logic        exp_dma_ack = 1'b0;
    logic [15:0] exp_cpu_data = '0;
    logic [15:0] exp_dma_data = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_fetching = 0; m_handing_back = 0; m_cvld = 0; m_last_dma = 1;
            exp_sdr_req = 0; exp_sdr_addr = '0; exp_cpu_ack = 0; exp_dma_ack = 0;
            exp_cpu_data = '0; exp_dma_data = '0;
        end else begin
            exp_cpu_ack = 0;
            exp_dma_ack = 0;
            if (m_handing_back) begin
                m_handing_back = 0;
            end else if (m_fetching) begin
                if (sdr_ack) begin
                    exp_sdr_req = 0;
                    m_fetching = 0;
                    m_handing_back = 1;
                    if (m_owner_dma) begin
                        exp_dma_ack = 1;
                        exp_dma_data = sdr_q;
                    end else begin
                        exp_cpu_ack = 1;
                        exp_cpu_data = sdr_q;
                        m_cvld = 1;
                        m_ctag = cpu_addr[19:1];
                        m_cdat = sdr_q;
                    end
                end
            end else begin
                m_hit = cpu_req && m_cvld && (m_ctag == cpu_addr[19:1]);
                if (m_hit) begin
                    exp_cpu_ack = 1;
                    exp_cpu_data = m_cdat;
                    m_handing_back = 1;
                    m_hits++;
                end else if (cpu_req || dma_req) begin
                    m_owner_dma = dma_req && (!cpu_req || !m_last_dma);
                    m_last_dma = m_owner_dma;
                    m_fetching = 1;
                    exp_sdr_req = 1;
                    if (m_owner_dma)
                        exp_sdr_addr = dma_addr & ~25'h1;
                    else
                        exp_sdr_addr = 25'(BASE + 25'(cpu_addr & 20'hFFFFE)) & ~25'h1;
                end
            end
            if (cache_flush) m_cvld = 0;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("sdr_req", {31'b0, sdr_req}, {31'b0, exp_sdr_req});
        chk("sdr_addr", {7'b0, sdr_addr}, {7'b0, exp_sdr_addr});
        chk("cpu_ack", {31'b0, cpu_ack}, {31'b0, exp_cpu_ack});
        chk("dma_ack", {31'b0, dma_ack}, {31'b0, exp_dma_ack});
        chk("cpu_data", {16'b0, cpu_data}, {16'b0, exp_cpu_data});
        chk("dma_data", {16'b0, dma_data}, {16'b0, exp_dma_data});
    end

    // ---------------- Directed helpers ----------------
    task automatic do_read(input bit is_dma, input logic [24:0] a, output logic [15:0] d,
                           output int cyc, output bit saw, output logic [24:0] sa);
        @(negedge clk);
        if (is_dma) begin dma_addr = a; dma_req = 1'b1; end
        else begin cpu_addr = a[19:0]; cpu_req = 1'b1; end
        cyc = 0; saw = 0; sa = '0;
        while (!(is_dma ? dma_ack : cpu_ack) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (sdr_req && !saw) begin saw = 1; sa = sdr_addr; end
        end
        chk(is_dma ? "dma_ack_seen" : "cpu_ack_seen", {31'b0, (is_dma ? dma_ack : cpu_ack)}, 32'd1);
        d = is_dma ? dma_data : cpu_data;
        if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
        @(negedge clk);
    endtask

    logic [15:0] d;
    int          cyc;
    bit          saw;
    logic [24:0] sa;
    int          order[$];
    logic [19:0] pool [4] = '{20'h00010, 20'h00012, 20'h7FFF0, 20'hFFFFE};

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_sdr_req", {31'b0, sdr_req}, 32'd0);
        chk("rst_sdr_addr", {7'b0, sdr_addr}, 32'd0);
        chk("rst_acks", {30'b0, cpu_ack, dma_ack}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // CPU miss then hit
        use_fixed = 1; fixed_lat = 5; fixed_data = 16'hBEEF;
        do_read(0, 25'h12345, d, cyc, saw, sa);
        chk("miss_sdr_addr", {7'b0, sa}, 32'h112344);
        chk("model_sdr_addr", {7'b0, exp_sdr_addr}, 32'h112344);
        chk("miss_data", {16'b0, d}, 32'hBEEF);
        chk("miss_latency", cyc, 7);
        do_read(0, 25'h12344, d, cyc, saw, sa);
        chk("hit_latency", cyc, 1);
        chk("hit_no_sdr", {31'b0, saw}, 32'd0);
        chk("hit_data", {16'b0, d}, 32'hBEEF);

        // Flush then same word misses
        @(negedge clk); flush_pulse = 1'b1;
        @(negedge clk); flush_pulse = 1'b0;
        fixed_data = 16'h1357;
        do_read(0, 25'h12344, d, cyc, saw, sa);
        chk("flush_miss", {31'b0, saw}, 32'd1);
        chk("flush_miss_data", {16'b0, d}, 32'h1357);

        // Flush coinciding with the fill: entry stays invalid, data unaffected
        fixed_data = 16'h2468; flush_on_ack = 1'b1;
        do_read(0, 25'h22222, d, cyc, saw, sa);
        flush_on_ack = 1'b0;
        chk("flush_fill_data", {16'b0, d}, 32'h2468);
        do_read(0, 25'h22222, d, cyc, saw, sa);
        chk("flush_fill_miss", {31'b0, saw}, 32'd1);

        // DMA path: no base offset, cache untouched
        fixed_data = 16'hCAFE;
        do_read(1, 25'h1ABCDE1, d, cyc, saw, sa);
        chk("dma_sdr_addr", {7'b0, sa}, 32'h1ABCDE0);
        chk("dma_data", {16'b0, d}, 32'hCAFE);
        do_read(0, 25'h22223, d, cyc, saw, sa);
        chk("post_dma_hit_latency", cyc, 1);
        chk("post_dma_hit_no_sdr", {31'b0, saw}, 32'd0);
        chk("post_dma_hit_data", {16'b0, d}, 32'h2468);

        // Spurious sdr_ack in IDLE
        spur_req_cnt++;
        repeat (4) begin
            @(negedge clk);
            chk("spur_no_ack", {30'b0, cpu_ack, dma_ack}, 32'd0);
            chk("spur_no_sdr_req", {31'b0, sdr_req}, 32'd0);
        end
        do_read(0, 25'h22222, d, cyc, saw, sa);
        chk("spur_then_hit", cyc, 1);

        // Contention: strict alternation starting with CPU
        use_fixed = 0;
        @(negedge clk);
        cpu_addr = 20'h30000; cpu_req = 1'b1;
        dma_addr = 25'h0400000; dma_req = 1'b1;
        cyc = 0;
        while (order.size() < 6 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (cpu_ack) begin order.push_back(0); cpu_req = 1'b0; end
            else if (!cpu_req) begin cpu_addr = cpu_addr + 20'd2; cpu_req = 1'b1; end
            if (dma_ack) begin order.push_back(1); dma_req = 1'b0; end
            else if (!dma_req) begin dma_addr = dma_addr + 25'd2; dma_req = 1'b1; end
        end
        while ((cpu_req || dma_req) && cyc < 500) begin
            @(negedge clk); cyc++;
            if (cpu_ack) cpu_req = 1'b0;
            if (dma_ack) dma_req = 1'b0;
        end
        chk("rr_count", (order.size() >= 6) ? 32'd6 : 32'(order.size()), 32'd6);
        for (int i = 0; i < 6 && i < order.size(); i++)
            chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
        @(negedge clk);

        // Reset mid-transfer
        use_fixed = 1; fixed_lat = 5; fixed_data = 16'h0F0F;
        @(negedge clk);
        cpu_addr = 20'h45678; cpu_req = 1'b1;
        cyc = 0;
        while (!sdr_req && cyc < 20) begin @(negedge clk); cyc++; end
        chk("rst_mid_pending", {31'b0, sdr_req}, 32'd1);
        #2 reset_n = 1'b0; cpu_req = 1'b0;
        #1;
        chk("rst_mid_sdr_req", {31'b0, sdr_req}, 32'd0);
        chk("rst_mid_acks", {30'b0, cpu_ack, dma_ack}, 32'd0);
        chk("rst_mid_data", {cpu_data, dma_data}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        do_read(0, 25'h45678, d, cyc, saw, sa);
        chk("rst_fresh_req", {31'b0, saw}, 32'd1);
        chk("rst_fresh_data", {16'b0, d}, 32'h0F0F);

        // Randomized traffic against the model
        use_fixed = 0; rand_spur = 1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            flush_pulse = ($urandom_range(0, 15) == 0);
            if (cpu_ack) cpu_req = 1'b0;
            else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_addr = pool[$urandom_range(0, 3)] | 20'($urandom_range(0, 1));
                cpu_req = 1'b1;
            end
            if (dma_ack) dma_req = 1'b0;
            else if (!dma_req && $urandom_range(0, 3) == 0) begin
                dma_addr = 25'($urandom);
                dma_req = 1'b1;
            end
        end
        flush_pulse = 1'b0; rand_spur = 0;
        cyc = 0;
        while ((cpu_req || dma_req) && cyc < 200) begin
            @(negedge clk); cyc++;
            if (cpu_ack) cpu_req = 1'b0;
            if (dma_ack) dma_req = 1'b0;
        end
        chk("drain_done", {30'b0, cpu_req, dma_req}, 32'd0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Shares the single SDRAM ROM read channel between the V33 CPU program-ROM fetch path and the sprite/tile DMA engine. The CPU side is fed by the address decoder's `cpu_rom_memrq` and translated 20-bit `rom_addr`. A one-entry last-word cache lets repeated CPU fetches of the same word complete without touching SDRAM. The block sits between the CPU bus logic and the SDRAM controller's ROM port. It owns arbitration, address offsetting and the request/acknowledge sequencing on both sides.

## Interface

Parameters:
- `CPU_ROM_BASE`, default `25'h000_0000`: SDRAM byte offset of the CPU ROM region.
- `SDR_AW`, default `25`: SDRAM byte address width.

Ports:
- `clk`  in  1  system clock; the block uses this single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU read request (`cpu_rom_memrq` & read strobe). Level; held until `cpu_ack`.
- `cpu_addr`  in  20  translated ROM byte address; bit 0 is ignored (word access).
- `cpu_data`  out  16  read data; valid while `cpu_ack`=1.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `dma_req`  in  1  DMA read request. Level; held until `dma_ack`.
- `dma_addr`  in  SDR_AW  DMA byte address, absolute; bit 0 is ignored.
- `dma_data`  out  16  read data; valid while `dma_ack`=1.
- `dma_ack`  out  1  one-cycle completion pulse.
- `cache_flush`  in  1  one-cycle pulse that invalidates the cache entry.
- `sdr_req`  out  1  SDRAM read request. Held until `sdr_ack`.
- `sdr_addr`  out  SDR_AW  SDRAM byte address; bit 0 is always 0.
- `sdr_q`  in  16  SDRAM read data; valid with `sdr_ack`.
- `sdr_ack`  in  1  one-cycle data-valid pulse from the SDRAM controller.

## Operation

State machine with four states: IDLE, CPU_WAIT, DMA_WAIT, RESP.

- **IDLE**
  - If `cpu_req`=1 and the cache entry is valid with tag equal to `cpu_addr[19:1]`: hit. Next state is RESP, `cpu_data` <= cached word, no SDRAM access.
  - Otherwise, with at least one request pending, choose a grantee:
    - Only one requester pending: grant it.
    - Both pending: grant DMA if `last_grant`=CPU, otherwise grant CPU (round robin).
    - A hit is always serviced first, and a hit does not update `last_grant`.
  - CPU grant:
    - `sdr_addr` <= `CPU_ROM_BASE` + {`cpu_addr[19:1]`, 0}
    - `sdr_req` <= 1, `last_grant` <= CPU, next state CPU_WAIT.
  - DMA grant:
    - `sdr_addr` <= {`dma_addr[SDR_AW-1:1]`, 0}
    - `sdr_req` <= 1, `last_grant` <= DMA, next state DMA_WAIT.
- **CPU_WAIT**: on `sdr_ack`:
  - `sdr_req` <= 0 and `cpu_data` <= `sdr_q`.
  - Cache entry <= {valid, `cpu_addr[19:1]`, `sdr_q`}.
  - Next state RESP.
- **DMA_WAIT**: on `sdr_ack`: `sdr_req` <= 0, `dma_data` <= `sdr_q`, next state RESP. The cache is not touched.
- **RESP**
  - The ack of the serviced requester is 1 for exactly this cycle.
  - Next state is always IDLE.
  - Requesters drop `req` in the cycle they see ack, so IDLE never re-services a completed request.
- `cpu_addr` and `dma_addr` must be held stable while the corresponding `req`=1.
- `sdr_ack` received in IDLE or RESP is ignored.
- `cache_flush` clears the valid bit in any state. If it coincides with a CPU_WAIT fill, the entry is left invalid; the flush wins. The data delivered to the CPU is unaffected.
- Address arithmetic is modulo 2^SDR_AW; there is no overflow detection.

## Timing

- **Reset** (`reset_n`=0, asynchronous): the state goes to IDLE and every output is forced as follows.
  - `sdr_req`=0, `sdr_addr`=0.
  - `cpu_ack`=0, `dma_ack`=0, `cpu_data`=0, `dma_data`=0.
  - Cache valid=0, `last_grant`=DMA, so the CPU wins the first contention.
- **Reset mid-transfer**: the outstanding SDRAM request is abandoned. The SDRAM controller shares the same reset.
- **Cache hit**: `req` is sampled at edge k and `ack` is high in cycle k+1. Latency is 1 cycle.
- **Miss**:
  - `req` is sampled at edge k; `sdr_req`/`sdr_addr` are valid from cycle k+1.
  - `sdr_ack` is sampled at edge m; `ack` and data are high in cycle m+1.
- **Back-to-back throughput**: the next grant occurs at the IDLE edge following RESP, i.e. at most one grant per 2 cycles plus the SDRAM latency.
- **Starvation bound**: with both requesters continuously requesting, grants strictly alternate. Neither requester waits more than one foreign transaction.
- **Outputs**: all outputs are registered, with no combinational path from inputs to outputs.

## Test plan

- **Reset values**: assert `reset_n`=0 mid CPU_WAIT (`sdr_req`=1) -> `sdr_req`, both acks and both data outputs read 0 immediately. The next `cpu_req` after release issues a fresh `sdr_req`.
- **CPU miss then hit**:
  - `cpu_req`, `cpu_addr`=20'h12345, `CPU_ROM_BASE`=25'h100000. Expect `sdr_addr`=25'h112344. SDRAM returns 16'hBEEF after 5 cycles -> `cpu_ack` with `cpu_data`=BEEF.
  - Repeat with `cpu_addr`=20'h12344 -> `cpu_ack` 1 cycle after `req` with BEEF, and `sdr_req` stays 0.
- **Flush**: after the fill above, pulse `cache_flush`, then `cpu_req` 20'h12344 -> `sdr_req` asserted (miss).
  - Also pulse `cache_flush` in the same cycle as `sdr_ack` -> the next same-address request misses.
- **Contention round robin**: hold `cpu_req` and `dma_req` high with fresh addresses for 6 transactions -> grant order CPU, DMA, CPU, DMA, CPU, DMA. Each ack lasts one cycle and goes only to its owner.
- **DMA path**: `dma_addr`=25'h1ABCDE1 -> `sdr_addr`=25'h1ABCDE0 with no base offset. `dma_data`=`sdr_q`. The cache is untouched: a following CPU request to the same word as the previously cached address still hits.
- **Spurious ack**: pulse `sdr_ack` while in IDLE -> no ack output, no state change.
